mem_wb_stage: RTL

Memory-access and write-back stage of the multicycle MIPS datapath. Takes the ALU result, store data and operation class from the execute side, runs a request/acknowledge transaction against data memory, and drives the register-file write port controls (`RF_WrEn`, `RF_WrData_sel`, `MEM_out`) consumed by the decode stage. It also reports misaligned accesses and memory timeouts to the control unit.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/byte_lane_extract.sv | 24 ++
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath.
// Holds the operation-class encodings driven by control and decoded by the
// decode and mem/write-back stages, plus the mem_wb_stage state encoding.
package mips_pkg;

  // Operation class carried alongside the ALU result.
  typedef enum logic [1:0] {
    OP_ALU = 2'b00,  // plain ALU write-back
    OP_LW  = 2'b01,  // load word
    OP_SW  = 2'b10,  // store word
    OP_LBU = 2'b11   // load byte, zero-extended
  } op_e;

  // mem_wb_stage sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WB   = 2'b10,
    ST_FIN  = 2'b11
  } mem_wb_state_e;

  // Loads are the only operations whose write-back data comes from memory.
  function automatic logic is_load(input op_e op);
    return (op == OP_LW) || (op == OP_LBU);
  endfunction

endpackage : mips_pkg

// File: rtl/byte_lane_extract.sv
// Selects one byte lane of a 32-bit word and zero-extends it.
// Ports:
//   word_i  - 32-bit source word
//   lane_i  - byte lane (0 = bits [7:0], 3 = bits [31:24])
//   byte_o  - selected byte, zero-extended to 32 bits
module byte_lane_extract (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] byte_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    byte_o = '0;
    case (lane_i)
      2'd0:    byte_o[7:0] = word_i[7:0];
      2'd1:    byte_o[7:0] = word_i[15:8];
      2'd2:    byte_o[7:0] = word_i[23:16];
      default: byte_o[7:0] = word_i[31:24];
    endcase
  end

endmodule : byte_lane_extract

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage of the multicycle MIPS datapath.
// Latches the operation on an accepted Start, runs one req/ack transaction
// against word-addressed data memory (or skips it for ALU ops and misaligned
// word accesses), then drives the register-file write controls.
// Ports:
//   Clk, Rst_n               - clock, synchronous active-low reset
//   Start, Op, ALU_out, RF_B - request from control / execute side
//   Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_RData, Mem_Ack - memory port
//   RF_WrEn, RF_WrData_sel, MEM_out - register-file write port controls
//   Busy, Done, Err          - status to control
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [31:0]       ALU_out,
  input  logic [31:0]       RF_B,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData,
  input  logic              Mem_Ack,
  output logic              RF_WrEn,
  output logic              RF_WrData_sel,
  output logic [31:0]       MEM_out,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  mem_wb_state_e     state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W+1:0] addr_q, addr_d;     // byte address, memory range only
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;       // REQ cycles spent so far
  logic [31:0]       mem_out_q, mem_out_d;
  logic              sel_q, sel_d;
  logic              err_q, err_d;
  logic [31:0]       byte_val;

  // Address bits above the data-memory range are intentionally not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ALU_out[31:ADDR_W+2];

  byte_lane_extract u_byte_lane (
    .word_i (Mem_RData),
    .lane_i (addr_q[1:0]),
    .byte_o (byte_val)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    mem_out_d = mem_out_q;
    sel_d     = sel_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d    = op_e'(Op);
          addr_d  = ALU_out[ADDR_W+1:0];
          wdata_d = RF_B;
          cnt_d   = '0;
          err_d   = 1'b0;
          case (op_e'(Op))
            OP_ALU: begin
              state_d = ST_WB;
              sel_d   = 1'b0;
            end
            OP_LW, OP_SW: begin
              // Word accesses must be aligned; byte loads never are checked.
              if (ALU_out[1:0] != 2'b00) begin
                state_d = ST_FIN;
                err_d   = 1'b1;
              end else begin
                state_d = ST_REQ;
              end
            end
            default: state_d = ST_REQ;
          endcase
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // An ack on the final allowed cycle still counts as success.
        if (Mem_Ack) begin
          if (op_q == OP_SW) begin
            state_d = ST_FIN;
          end else begin
            mem_out_d = (op_q == OP_LBU) ? byte_val : Mem_RData;
            sel_d     = is_load(op_q);
            state_d   = ST_WB;
          end
        end else if (cnt_d == TIMEOUT_C) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end
      end

      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ALU;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      mem_out_q <= '0;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      mem_out_q <= mem_out_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
    end
  end

  // Moore outputs: memory port fields are zero outside REQ.
  assign Mem_Req       = (state_q == ST_REQ);
  assign Mem_We        = Mem_Req && (op_q == OP_SW);
  assign Mem_Addr      = Mem_Req ? addr_q[ADDR_W+1:2] : '0;
  assign Mem_WData     = Mem_Req ? wdata_q : '0;
  assign RF_WrEn       = (state_q == ST_WB);
  assign RF_WrData_sel = sel_q;
  assign MEM_out       = mem_out_q;
  assign Busy          = (state_q != ST_IDLE);
  assign Done          = (state_q == ST_WB) || (state_q == ST_FIN);
  assign Err           = err_q;

endmodule : mem_wb_stage
